// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl -- multi-cycle instruction sequencer for the single-issue MIPS core.
//
// Owns the PC register and the FETCH/DECODE/EXEC/MEM/WB state machine. It
// fetches through a request/acknowledge handshake, decodes the opcode held in
// IR, steers the next-PC unit (pc_sel, bltzal) and produces every datapath
// write strobe. The PC loads `npc` exactly once per retired instruction.
//
// Optional feature macro: PC_CTRL_PERF_EN
//   When defined, adds free-running `retired` and `cycles` counters.
//
// Parameters:
//   RESET_PC   PC value loaded by reset
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   if_req     instruction fetch request (held in FETCH until if_ack)
//   if_ack     instruction memory presents a valid `instr` this cycle
//   instr      fetched instruction word
//   stall      freeze state, PC, IR and every strobe except if_req
//   npc        next PC computed by the next-PC unit
//   pc         current PC register
//   pc_sel     next-PC select: 00 pc+4, 01 branch, 10 j/jal, 11 jr
//   bltzal     current instruction is bltzal
//   ir_we      latch `instr` into IR
//   pc_we      load `npc` into `pc` at this edge
//   reg_we     GPR write strobe (addu/subu/ori/lui/lw)
//   link_we    write pc+4 to $31 (jal, bltzal)
//   mem_we     data memory write strobe (sw)
//   illegal    sticky flag: unsupported instruction executed since reset
//   retired    (PC_CTRL_PERF_EN) count of pc_we pulses
//   cycles     (PC_CTRL_PERF_EN) count of non-reset cycles
// -----------------------------------------------------------------------------
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        if_req,
    input  logic        if_ack,
    input  logic [31:0] instr,
    input  logic        stall,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        bltzal,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        link_we,
    output logic        mem_we,
    output logic        illegal
`ifdef PC_CTRL_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] cycles
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;

    state_t     state;

    // Only the fields the controller decodes are kept; the rest of the word
    // goes to the datapath's own IR copy.
    logic [5:0] ir_op;
    logic [4:0] ir_rt;
    logic [5:0] ir_funct;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[25:21], instr[15:6]};

    // ------------------------------------------------------------------------
    // Decode of the held instruction
    // ------------------------------------------------------------------------
    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_bltzal;
    logic is_alu, is_ctrl, is_legal;

    assign is_addu   = (ir_op == OP_SPECIAL) && (ir_funct == FN_ADDU);
    assign is_subu   = (ir_op == OP_SPECIAL) && (ir_funct == FN_SUBU);
    assign is_jr     = (ir_op == OP_SPECIAL) && (ir_funct == FN_JR);
    assign is_ori    = (ir_op == OP_ORI);
    assign is_lui    = (ir_op == OP_LUI);
    assign is_lw     = (ir_op == OP_LW);
    assign is_sw     = (ir_op == OP_SW);
    assign is_beq    = (ir_op == OP_BEQ);
    assign is_j      = (ir_op == OP_J);
    assign is_jal    = (ir_op == OP_JAL);
    assign is_bltzal = (ir_op == OP_REGIMM) && (ir_rt == RT_BLTZAL);

    assign is_alu    = is_addu | is_subu | is_ori | is_lui;
    assign is_ctrl   = is_beq | is_bltzal | is_j | is_jal | is_jr;
    assign is_legal  = is_alu | is_ctrl | is_lw | is_sw;

    // ------------------------------------------------------------------------
    // Strobes: combinational from state and IR. Reset and stall suppress every
    // write; if_req survives a stall so the fetch is simply retried.
    // ------------------------------------------------------------------------
    logic active;
    assign active = !reset && !stall;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        if_req  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_we  = 1'b0;
        link_we = 1'b0;
        mem_we  = 1'b0;
        pc_sel  = 2'b00;
        bltzal  = 1'b0;

        if (state != S_FETCH) begin
            bltzal = is_bltzal;
            if (is_beq || is_bltzal) pc_sel = 2'b01;
            else if (is_j || is_jal) pc_sel = 2'b10;
            else if (is_jr)          pc_sel = 2'b11;
        end

        case (state)
            S_FETCH: begin
                if_req = !reset;
                ir_we  = active && if_ack;
            end
            S_EXEC: begin
                // Control flow and unsupported opcodes retire here.
                pc_we   = active && (is_ctrl || !is_legal);
                link_we = active && (is_jal || is_bltzal);
            end
            S_MEM: begin
                pc_we  = active && is_sw;
                mem_we = active && is_sw;
            end
            S_WB: begin
                pc_we  = active;
                reg_we = active;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // State, PC and sticky illegal flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            illegal <= 1'b0;
        end else begin
            if (pc_we) pc <= npc;
            if (state == S_EXEC && active && !is_legal) illegal <= 1'b1;

            if (!stall) begin
                case (state)
                    S_FETCH:  if (if_ack) state <= S_DECODE;
                    S_DECODE: state <= S_EXEC;
                    S_EXEC: begin
                        if (is_lw || is_sw) state <= S_MEM;
                        else if (is_alu)    state <= S_WB;
                        else                state <= S_FETCH;
                    end
                    S_MEM:    state <= is_lw ? S_WB : S_FETCH;
                    S_WB:     state <= S_FETCH;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end

    // NOTE: IR has no reset; it is only interpreted outside FETCH, and every
    // path out of FETCH loads it first.
    always_ff @(posedge clk) begin
        if (ir_we) begin
            ir_op    <= instr[31:26];
            ir_rt    <= instr[20:16];
            ir_funct <= instr[5:0];
        end
    end

`ifdef PC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (pc_we) retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl -- self-checking bench for pc_ctrl.
//
// A transaction-level model tracks, per instruction, how many cycles it has
// spent since its fetch was accepted and what it must do in its final cycle
// (latency and strobe set come straight from the instruction's class). A
// negedge compare process checks every output every cycle against it. A
// directed section pins the model with hand-computed values, then a random
// section drives random instructions, fetch waits, stalls, resets and npc.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, if_ack, stall;
    logic [31:0] instr, npc;
    logic        if_req, bltzal, ir_we, pc_we, reg_we, link_we, mem_we, illegal;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
`ifdef PC_CTRL_PERF_EN
    logic [31:0] retired, cycles;
`endif

    pc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_ack  (if_ack),
        .instr   (instr),
        .stall   (stall),
        .npc     (npc),
        .pc      (pc),
        .pc_sel  (pc_sel),
        .bltzal  (bltzal),
        .ir_we   (ir_we),
        .pc_we   (pc_we),
        .reg_we  (reg_we),
        .link_we (link_we),
        .mem_we  (mem_we),
        .illegal (illegal)
`ifdef PC_CTRL_PERF_EN
        ,
        .retired (retired),
        .cycles  (cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Instruction classification from the ISA table: total cycles from the
    // accepted fetch to retirement, next-PC select and final-cycle strobes.
    // ------------------------------------------------------------------------
    function automatic void classify(input logic [31:0] w, output int len,
                                     output logic [1:0] sel, output logic bl,
                                     output logic rw, output logic lk,
                                     output logic mw, output logic ill);
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        op = w[31:26]; fn = w[5:0]; rt = w[20:16];
        len = 3; sel = 2'b00; bl = 1'b0; rw = 1'b0; lk = 1'b0; mw = 1'b0; ill = 1'b0;
        case (op)
            6'h00: begin
                if (fn == 6'h21 || fn == 6'h23) begin len = 4; rw = 1'b1; end
                else if (fn == 6'h08)           sel = 2'b11;
                else                            ill = 1'b1;
            end
            6'h0d, 6'h0f: begin len = 4; rw = 1'b1; end
            6'h23:        begin len = 5; rw = 1'b1; end
            6'h2b:        begin len = 4; mw = 1'b1; end
            6'h04:        sel = 2'b01;
            6'h02:        sel = 2'b10;
            6'h03:        begin sel = 2'b10; lk = 1'b1; end
            6'h01: begin
                if (rt == 5'b10000) begin sel = 2'b01; bl = 1'b1; lk = 1'b1; end
                else                ill = 1'b1;
            end
            default:      ill = 1'b1;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------------
    bit          m_valid = 1'b0;
    bit          m_fetch = 1'b1;
    int          m_step  = 0;
    logic [31:0] m_ins   = '0;
    logic [31:0] m_pc    = '0;
    bit          m_ill   = 1'b0;
    logic [31:0] m_retired = '0;
    logic [31:0] m_cycles  = '0;

    always @(posedge clk) begin
        int len; logic [1:0] sel; logic bl, rw, lk, mw, ill;
        if (reset) begin
            m_valid = 1'b1; m_fetch = 1'b1; m_step = 0;
            m_pc = RESET_PC; m_ill = 1'b0; m_retired = '0; m_cycles = '0;
        end else if (m_valid) begin
            m_cycles = m_cycles + 1;
            if (!stall) begin
                if (m_fetch) begin
                    if (if_ack) begin m_ins = instr; m_fetch = 1'b0; m_step = 1; end
                end else begin
                    classify(m_ins, len, sel, bl, rw, lk, mw, ill);
                    if (m_step == len - 1) begin
                        m_pc = npc; m_fetch = 1'b1; m_retired = m_retired + 1;
                        if (ill) m_ill = 1'b1;
                    end else begin
                        m_step++;
                    end
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        int len; logic [1:0] sel; logic bl, rw, lk, mw, ill;
        logic act, fin;
        if (m_valid) begin
            classify(m_ins, len, sel, bl, rw, lk, mw, ill);
            act = !reset && !stall;
            fin = !m_fetch && (m_step == len - 1);
            check("pc",      pc,      m_pc);
            check("illegal", {31'b0, illegal}, {31'b0, m_ill});
            check("if_req",  {31'b0, if_req},  {31'b0, m_fetch && !reset});
            check("ir_we",   {31'b0, ir_we},   {31'b0, m_fetch && if_ack && act});
            check("pc_we",   {31'b0, pc_we},   {31'b0, fin && act});
            check("reg_we",  {31'b0, reg_we},  {31'b0, fin && act && rw});
            check("link_we", {31'b0, link_we}, {31'b0, fin && act && lk});
            check("mem_we",  {31'b0, mem_we},  {31'b0, fin && act && mw});
            check("pc_sel",  {30'b0, pc_sel},  {30'b0, m_fetch ? 2'b00 : sel});
            check("bltzal",  {31'b0, bltzal},  {31'b0, !m_fetch && bl});
`ifdef PC_CTRL_PERF_EN
            check("retired", retired, m_retired);
            check("cycles",  cycles,  m_cycles);
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    localparam logic [31:0] ADDU   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] BEQ    = {6'h04, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] BLTZAL = {6'h01, 5'd3, 5'b10000, 16'h0010};
    localparam logic [31:0] LW     = {6'h23, 5'd4, 5'd5, 16'h0008};
    localparam logic [31:0] SW     = {6'h2b, 5'd4, 5'd5, 16'h000c};
    localparam logic [31:0] ILL    = 32'hFC00_0000;

    // Apply one cycle of inputs just after the rising edge, return at the
    // following falling edge where outputs are settled.
    task automatic cyc(input logic r, input logic st, input logic ack,
                       input logic [31:0] ins, input logic [31:0] np);
        @(posedge clk);
        #1;
        reset = r; stall = st; if_ack = ack; instr = ins; npc = np;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] f;
        f = $urandom;
        case ($urandom_range(0, 11))
            0:  return {6'h00, f[25:6], 6'h21};
            1:  return {6'h00, f[25:6], 6'h23};
            2:  return {6'h00, f[25:6], 6'h08};
            3:  return {6'h0d, f[25:0]};
            4:  return {6'h0f, f[25:0]};
            5:  return {6'h23, f[25:0]};
            6:  return {6'h2b, f[25:0]};
            7:  return {6'h04, f[25:0]};
            8:  return {6'h02, f[25:0]};
            9:  return {6'h03, f[25:0]};
            10: return {6'h01, f[25:21], 5'b10000, f[15:0]};
            default: begin
                case ($urandom_range(0, 2))
                    0:       return {6'h3f, f[25:0]};
                    1:       return {6'h00, f[25:6], 6'h20};
                    default: return {6'h01, f[25:21], 5'b00001, f[15:0]};
                endcase
            end
        endcase
    endfunction

    initial begin
        int nreq, nrw, nmw;
        logic [31:0] np;
        reset = 1'b1; stall = 1'b0; if_ack = 1'b0; instr = '0; npc = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        check("rst_pc", pc, 32'h3000);
        check("rst_if_req", {31'b0, if_req}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);

        // addu, zero-wait: reg_we in cycle 4, pc 0x3004 afterwards
        cyc(0, 0, 1, ADDU, 0);
        check("addu_c1_pc", pc, 32'h3000);
        check("addu_c1_ir_we", {31'b0, ir_we}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("addu_c3_reg_we", {31'b0, reg_we}, 32'd0);
        cyc(0, 0, 0, 0, 32'h3004);
        check("addu_c4_reg_we", {31'b0, reg_we}, 32'd1);
        check("addu_c4_pc", pc, 32'h3000);

        // beq taken to 0x3010
        cyc(0, 0, 1, BEQ, 0);
        check("beq_c1_pc", pc, 32'h3004);
        cyc(0, 0, 0, 0, 0);
        check("beq_dec_pc_sel", {30'b0, pc_sel}, 32'd1);
        cyc(0, 0, 0, 0, 32'h3010);
        check("beq_c3_pc_we", {31'b0, pc_we}, 32'd1);
        check("beq_c3_reg_we", {31'b0, reg_we}, 32'd0);

        // bltzal: link and pc write together
        cyc(0, 0, 1, BLTZAL, 0);
        check("bltzal_fetch_pc", pc, 32'h3010);
        cyc(0, 0, 0, 0, 0);
        check("bltzal_flag", {31'b0, bltzal}, 32'd1);
        check("bltzal_pc_sel", {30'b0, pc_sel}, 32'd1);
        cyc(0, 0, 0, 0, 32'h3100);
        check("bltzal_link_we", {31'b0, link_we}, 32'd1);
        check("bltzal_pc_we", {31'b0, pc_we}, 32'd1);

        // lw with two fetch wait cycles: 7 cycles total
        nreq = 0; nrw = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, (i == 2), LW, (i == 6) ? 32'h3104 : 32'h0);
            nreq += int'(if_req);
            nrw  += int'(reg_we);
        end
        check("lw_c7_reg_we", {31'b0, reg_we}, 32'd1);
        check("lw_if_req_cycles", nreq, 32'd3);
        check("lw_reg_we_count", nrw, 32'd1);

        // sw with 3 stall cycles in MEM, starting from a fresh reset
        cyc(1, 0, 0, 0, 0);
        check("lw_done_pc", pc, 32'h3104);
        check("rst2_if_req", {31'b0, if_req}, 32'd0);
        cyc(0, 0, 1, SW, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        nmw = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            nmw += int'(mem_we);
        end
        check("sw_stall_mem_we", nmw, 32'd0);
        cyc(0, 0, 0, 0, 32'h3008);
        check("sw_mem_we", {31'b0, mem_we}, 32'd1);
        check("sw_pc_we", {31'b0, pc_we}, 32'd1);

        // Unsupported opcode 0x3F, then reset during EXEC of the next one
        cyc(0, 0, 1, ILL, 0);
        check("sw_done_pc", pc, 32'h3008);
`ifdef PC_CTRL_PERF_EN
        check("perf_retired", retired, 32'd1);
        check("perf_cycles", cycles, 32'd7);
`endif
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h300c);
        check("ill_pc_we", {31'b0, pc_we}, 32'd1);
        check("ill_pc_sel", {30'b0, pc_sel}, 32'd0);
        cyc(0, 0, 1, ADDU, 0);
        check("ill_sticky", {31'b0, illegal}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'h5555_0000);
        check("rst_exec_strobes", {26'b0, if_req, ir_we, pc_we, reg_we, link_we, mem_we}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("post_rst_illegal", {31'b0, illegal}, 32'd0);
        check("post_rst_pc", pc, 32'h3000);
        check("post_rst_if_req", {31'b0, if_req}, 32'd1);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 9))
                0:       np = 32'hFFFF_FFFC;
                1:       np = 32'h0;
                default: np = $urandom;
            endcase
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 1)), rand_instr(), np);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Multi-cycle instruction sequencer for the single-issue MIPS core. It owns the PC register, runs the fetch/decode/execute/memory/writeback state machine, and drives the next-PC unit's `pc_sel` and `bltzal` controls. It loads the next-PC result into the PC once per retired instruction and handshakes with instruction memory, producing all datapath write strobes.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  out  1  instruction fetch request, held until if_ack
- if_ack  in  1  instruction memory has `instr` valid this cycle
- instr  in  32  fetched instruction word
- stall  in  1  freeze FSM and all strobes this cycle
- npc  in  32  next PC from the next-PC unit
- pc  out  32  current PC register
- pc_sel  out  2  next-PC select: 00 pc+4, 01 branch, 10 j/jal, 11 jr
- bltzal  out  1  current instruction is bltzal
- ir_we  out  1  latch `instr` into IR
- pc_we  out  1  load `npc` into `pc` at this edge
- reg_we  out  1  GPR write strobe (R-type/ori/lui/lw)
- link_we  out  1  write pc+4 to $31 (jal, bltzal)
- mem_we  out  1  data memory write strobe (sw)
- illegal  out  1  sticky: unsupported opcode decoded since reset

## Operation
- Decoded set: addu, subu, jr (op 0, funct 21/23/08), ori 0d, lui 0f, lw 23, sw 2b, beq 04, j 02, jal 03, bltzal (op 01, rt 10000). The opcode is held in IR, captured on `ir_we`.
- States: FETCH, DECODE, EXEC, MEM, WB. Encoding is internal.
- FETCH: `if_req`=1. On `if_ack`, `ir_we`=1 and go to DECODE. Otherwise stay.
- DECODE: always go to EXEC. `pc_sel`/`bltzal` become valid from this state until the instruction retires.
- EXEC:
  - beq, bltzal, j, jal, jr: `pc_we`=1 and go to FETCH (3-state instruction). `link_we`=1 for jal and bltzal; bltzal links unconditionally.
  - lw, sw: go to MEM.
  - R-type, ori, lui: go to WB.
  - Unsupported opcode: treat as nop. Set `illegal`, assert `pc_we` with `pc_sel`=00, go to FETCH.
- MEM:
  - sw: `mem_we`=1, `pc_we`=1, go to FETCH.
  - lw: go to WB.
- WB: `reg_we`=1, `pc_we`=1, `pc_sel`=00, go to FETCH.
- Branch condition (zero / rs<0) is evaluated by the next-PC unit. The controller only selects 01; `pc` takes whatever `npc` presents.
- `pc_sel`=00 and `bltzal`=0 in FETCH and for non-control-flow instructions.

## Timing
- Reset values: `pc`=RESET_PC, state=FETCH, `illegal`=0. While `reset`=1, all strobes are 0 (`if_req`, `ir_we`, `pc_we`, `reg_we`, `link_we`, `mem_we`).
- Reset mid-instruction: the instruction is abandoned with no strobe and no PC update. The first fetch after reset is at RESET_PC.
- Strobes are combinational from the state register and IR, each asserted for exactly one cycle per instruction.
- `stall`=1: state, `pc`, and IR hold. Every strobe except `if_req` is forced 0. An `if_ack` arriving under stall is ignored, and the fetch repeats.
- Latency in cycles, with zero-wait fetch:
  - Branch/jump/jr: 3
  - sw, R-type, ori, lui: 4
  - lw: 5
  - Each fetch wait cycle adds 1.
- `pc` updates at the edge where `pc_we`=1, so the new `pc` is visible in the next cycle's FETCH.
- Wrap-around: the PC is 32-bit and wraps silently (0xFFFF_FFFC + 4 = 0).

## Configuration
- `PC_CTRL_PERF_EN`:
  - Defined: adds outputs `retired` [31:0] and `cycles` [31:0]. Both reset to 0.
  - `retired` increments on every `pc_we` pulse. `cycles` increments every non-reset cycle, including stalls. Both wrap at 2^32.
  - Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then zero-wait ack on `addu` → `pc`=0x3000 through 4 cycles, `reg_we` pulse in cycle 4, `pc`=0x3004 afterwards.
- beq with next-PC unit returning 0x3010 → `pc_sel`=01 from DECODE, `pc_we` in cycle 3, next FETCH at 0x3010, no `reg_we`.
- bltzal (op 01, rt 10000) → `bltzal`=1, `pc_sel`=01, `link_we`=1 and `pc_we`=1 in the same cycle.
- lw with `if_ack` delayed 2 cycles → `if_req` held 3 cycles, 7 cycles total, single `reg_we`.
- `stall`=1 for 3 cycles in MEM of sw → `mem_we` fires exactly once after release. With `PC_CTRL_PERF_EN`: `retired`=1, `cycles`=7.
- Opcode 0x3F, then `reset` asserted in EXEC of the next instruction → `illegal`=1 then 0, `pc`=0x3000, no strobes during reset.
